// File: rtl/ks_sched_pkg.sv
// Shared types and constants for the Karplus-Strong note scheduler.
package ks_sched_pkg;

  localparam int KS_SCHED_CNT_W = 16;
  localparam int KS_MIN_PERIOD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_PLUCK  = 3'd2,
    ST_BURST  = 3'd3,
    ST_HOLD   = 3'd4
  } ks_sched_state_t;

endpackage

// File: rtl/ks_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer; the pointer moves past the winner when the grant is consumed.
module ks_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       en_i,
  input  logic                       advance_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        grant_o[cand]  = 1'b1;
      end
    end
  end

  // Next pointer: one past the winner, wrapping to zero.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (idx_o == LAST_IDX) ? '0 : idx_o + 1'b1;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ks_note_scheduler.sv
// Note scheduler sharing one ks_string voice among NUM_REQ requesters.
// Each granted note runs SETTLE (freeze + retune), PLUCK, BURST (period+2)
// and HOLD (minimum note time) before the voice can be granted again.
// Optional: define KS_SCHED_STEAL_EN to let a pending request cut HOLD short.
module ks_note_scheduler
  import ks_sched_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_LENGTH      = 64,
  parameter int SETTLE_CYCLES   = 2,
  parameter int PLUCK_CYCLES    = 4,
  parameter int MIN_NOTE_CYCLES = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_period_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dyn_R_i,
  input  logic [NUM_REQ-1:0]            req_drum_i,
  output logic [DATA_WIDTH-1:0]         period_o,
  output logic [DATA_WIDTH-1:0]         dynamics_R_o,
  output logic                          dynamics_en_o,
  output logic                          drum_string_no,
  output logic                          pluck_o,
  output logic                          freeze_o,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          note_done_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [KS_SCHED_CNT_W-1:0] SETTLE_LAST = KS_SCHED_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [KS_SCHED_CNT_W-1:0] PLUCK_LAST  = KS_SCHED_CNT_W'(PLUCK_CYCLES - 1);
  localparam logic [KS_SCHED_CNT_W-1:0] HOLD_LAST   = KS_SCHED_CNT_W'(MIN_NOTE_CYCLES - 1);

  // Requested periods outside [KS_MIN_PERIOD, MAX_LENGTH] are pinned to the edge.
  function automatic logic [DATA_WIDTH-1:0] clamp_period(input logic [DATA_WIDTH-1:0] p);
    logic [DATA_WIDTH-1:0] r;
    if (int'(p) < KS_MIN_PERIOD) begin
      r = DATA_WIDTH'(KS_MIN_PERIOD);
    end else if (int'(p) > MAX_LENGTH) begin
      r = DATA_WIDTH'(MAX_LENGTH);
    end else begin
      r = p;
    end
    return r;
  endfunction

  ks_sched_state_t             state_q, state_d;
  logic [KS_SCHED_CNT_W-1:0]   cnt_q, cnt_d;
  logic [KS_SCHED_CNT_W-1:0]   burst_last;

  logic [DATA_WIDTH-1:0]       period_q, period_d;
  logic [DATA_WIDTH-1:0]       dyn_q, dyn_d;
  logic                        dyn_en_q, dyn_en_d;
  logic                        drum_q, drum_d;
  logic                        pluck_q, pluck_d;
  logic                        freeze_q, freeze_d;
  logic                        busy_q, busy_d;
  logic [IDX_W-1:0]            gid_q, gid_d;
  logic                        done_q, done_d;

  logic [NUM_REQ-1:0]          arb_grant;
  logic [IDX_W-1:0]            arb_idx;
  logic                        arb_en;
  logic                        grant_any;

  // Grants only from IDLE; ready is also forced low while reset is held.
  assign arb_en     = enable_i && rst_n && (state_q == ST_IDLE);
  assign grant_any  = |arb_grant;
  assign burst_last = KS_SCHED_CNT_W'(period_q) + KS_SCHED_CNT_W'(1);

  ks_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .req_i     (req_valid_i),
    .en_i      (arb_en),
    .advance_i (grant_any),
    .grant_o   (arb_grant),
    .idx_o     (arb_idx)
  );

  assign req_ready_o = arb_grant;

  // Next state and phase counter; the counter restarts at every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (grant_any) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_PLUCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PLUCK: begin
        if (cnt_q == PLUCK_LAST) begin
          state_d = ST_BURST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BURST: begin
        if (cnt_q == burst_last) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
`ifdef KS_SCHED_STEAL_EN
        // A waiting request jumps to the final HOLD cycle so done fires next.
        else if (enable_i && (|req_valid_i)) begin
          cnt_d = HOLD_LAST;
        end
`endif
        else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered voice controls, derived from the upcoming state so they align with it.
  always_comb begin
    period_d = period_q;
    dyn_d    = dyn_q;
    drum_d   = drum_q;
    gid_d    = gid_q;
    if (grant_any) begin
      period_d = clamp_period(req_period_i[arb_idx*DATA_WIDTH +: DATA_WIDTH]);
      dyn_d    = req_dyn_R_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
      drum_d   = req_drum_i[arb_idx];
      gid_d    = arb_idx;
    end
    dyn_en_d = (dyn_d != '0);
    freeze_d = (state_d == ST_SETTLE);
    pluck_d  = (state_d == ST_PLUCK);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_HOLD) && (cnt_d == HOLD_LAST);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= DATA_WIDTH'(MAX_LENGTH);
      dyn_q    <= '0;
      dyn_en_q <= 1'b0;
      drum_q   <= 1'b0;
      pluck_q  <= 1'b0;
      freeze_q <= 1'b0;
      busy_q   <= 1'b0;
      gid_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      dyn_q    <= dyn_d;
      dyn_en_q <= dyn_en_d;
      drum_q   <= drum_d;
      pluck_q  <= pluck_d;
      freeze_q <= freeze_d;
      busy_q   <= busy_d;
      gid_q    <= gid_d;
      done_q   <= done_d;
    end
  end

  assign period_o       = period_q;
  assign dynamics_R_o   = dyn_q;
  assign dynamics_en_o  = dyn_en_q;
  assign drum_string_no = drum_q;
  assign pluck_o        = pluck_q;
  assign freeze_o       = freeze_q;
  assign busy_o         = busy_q;
  assign grant_id_o     = gid_q;
  assign note_done_o    = done_q;

endmodule

// File: tb/tb_ks_note_scheduler.sv
// Bench for ks_note_scheduler: random note traffic checked against a
// note-level reference (round-robin pick, clamp, phase lengths, stealing).
module tb_ks_note_scheduler;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int ML    = 64;
  localparam int S     = 2;
  localparam int PL    = 4;
  localparam int MIN   = 256;
  localparam int IDX_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable_i = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [N-1:0]      req_drum_i = '0;
  logic [DW-1:0]     per_a [N];
  logic [DW-1:0]     dyn_a [N];
  logic [N*DW-1:0]   req_period_i;
  logic [N*DW-1:0]   req_dyn_R_i;
  logic [DW-1:0]     period_o, dynamics_R_o;
  logic              dynamics_en_o, drum_string_no, pluck_o, freeze_o, busy_o, note_done_o;
  logic [IDX_W-1:0]  grant_id_o;

  typedef struct {
    int           k;
    logic [N-1:0] v;
    logic         en;
    logic         rnd;
  } act_t;
  act_t acts[$];

  int checks = 0;
  int failures = 0;
  int model_ptr = 0;
  logic [DW-1:0] seen_period;

  always #5 clk = ~clk;

  always_comb begin
    req_period_i = '0;
    req_dyn_R_i  = '0;
    for (int r = 0; r < N; r++) begin
      req_period_i[r*DW +: DW] = per_a[r];
      req_dyn_R_i[r*DW +: DW]  = dyn_a[r];
    end
  end

  ks_note_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_LENGTH(ML),
    .SETTLE_CYCLES(S), .PLUCK_CYCLES(PL), .MIN_NOTE_CYCLES(MIN)
  ) dut (
    .clk_i          (clk),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_period_i   (req_period_i),
    .req_dyn_R_i    (req_dyn_R_i),
    .req_drum_i     (req_drum_i),
    .period_o       (period_o),
    .dynamics_R_o   (dynamics_R_o),
    .dynamics_en_o  (dynamics_en_o),
    .drum_string_no (drum_string_no),
    .pluck_o        (pluck_o),
    .freeze_o       (freeze_o),
    .busy_o         (busy_o),
    .grant_id_o     (grant_id_o),
    .note_done_o    (note_done_o)
  );

  // Reference: first valid requester at or after the pointer, -1 if none.
  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (v[IDX_W'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic int clamp_ref(input int p);
    if (p < 2) return 2;
    if (p > ML) return ML;
    return p;
  endfunction

  task automatic randomize_fields();
    for (int r = 0; r < N; r++) begin
      per_a[r] = DW'($urandom);
      dyn_a[r] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
    end
    req_drum_i = N'($urandom);
  endtask

  // Called in a cycle where inputs are settled: checks the grant the model
  // predicts, then follows the whole note against its phase timeline.
  task automatic play_note(input int stop_k, output int g, output int end_k);
    int ep, hold0;
    logic [DW-1:0] ed;
    logic          edrum;
    logic [7:0]    ctrl_e, ctrl_a;
    logic [19:0]   data_e, data_a;
    g = enable_i ? rr_pick(req_valid_i, model_ptr) : -1;
    checks++;
    if (req_ready_o !== ((g < 0) ? 4'b0000 : (4'b0001 << g))) begin
      failures++;
      $display("FAIL grant_ready got=%b expected_id=%0d", req_ready_o, g);
    end
    end_k = 0;
    if (g < 0) begin
      acts.delete();
      return;
    end
    ep    = clamp_ref(int'(per_a[g]));
    ed    = dyn_a[g];
    edrum = req_drum_i[IDX_W'(g)];
    model_ptr = (g + 1) % N;
    hold0 = S + PL + ep + 3;
    end_k = S + PL + ep + 2 + MIN;
    for (int k = 1; k <= end_k; k++) begin
      @(posedge clk); #1;
      foreach (acts[i]) begin
        if (acts[i].k == k) begin
          req_valid_i = acts[i].v;
          enable_i    = acts[i].en;
          if (acts[i].rnd) randomize_fields();
        end
      end
      #1;
      if (k == 1) seen_period = period_o;
      ctrl_e = {(k <= S), (k > S && k <= S + PL), 1'b1, (k == end_k), 4'b0000};
      ctrl_a = {freeze_o, pluck_o, busy_o, note_done_o, req_ready_o};
      checks++;
      if (ctrl_a !== ctrl_e) begin
        failures++;
        $display("FAIL note_ctrl k=%0d got=%b expected=%b", k, ctrl_a, ctrl_e);
      end
      data_e = {DW'(ep), ed, (ed != 0), edrum, IDX_W'(g)};
      data_a = {period_o, dynamics_R_o, dynamics_en_o, drum_string_no, grant_id_o};
      checks++;
      if (data_a !== data_e) begin
        failures++;
        $display("FAIL note_data k=%0d got=%h expected=%h", k, data_a, data_e);
      end
      if (stop_k != 0 && k == stop_k) begin
        end_k = k;
        break;
      end
`ifdef KS_SCHED_STEAL_EN
      if (k >= hold0 && k + 1 < end_k && enable_i && (|req_valid_i)) end_k = k + 1;
`endif
    end
    acts.delete();
  endtask

  task automatic test_reset();
    logic [27:0] got;
    rst_n = 1'b0;
    enable_i = 1'b1;
    req_valid_i = '1;
    randomize_fields();
    repeat (3) @(posedge clk);
    #1;
    got = {period_o, dynamics_R_o, dynamics_en_o, drum_string_no, pluck_o, freeze_o,
           busy_o, grant_id_o, note_done_o, req_ready_o};
    checks++;
    if (got !== {8'd64, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state got=%h expected=%h", got, {8'd64, 20'd0});
    end
    req_valid_i = '0;
    #1 rst_n = 1'b1;
    model_ptr = 0;
    @(posedge clk); #2;
    checks++;
    if ({busy_o, req_ready_o, period_o} !== {1'b0, 4'b0000, 8'd64}) begin
      failures++;
      $display("FAIL idle_after_reset got=%h expected=%h", {busy_o, req_ready_o, period_o}, 13'h040);
    end
  endtask

  task automatic test_single();
    int g, e;
    @(posedge clk); #1;
    per_a[0] = 8'd10;
    dyn_a[0] = 8'h5a;
    req_drum_i = 4'b0001;
    enable_i = 1'b1;
    req_valid_i = 4'b0001;
    #1;
    acts.push_back('{1, 4'b0000, 1'b1, 1'b0});
    play_note(0, g, e);
    checks++;
    if (g != 0) begin failures++; $display("FAIL single_grant got=%0d expected=0", g); end
    checks++;
    if (e != 274) begin failures++; $display("FAIL single_done_cycle got=%0d expected=274", e); end
    @(posedge clk); #2;
    checks++;
    if ({busy_o, req_ready_o, note_done_o} !== 6'b0) begin
      failures++;
      $display("FAIL single_idle got=%b expected=000000", {busy_o, req_ready_o, note_done_o});
    end
  endtask

  task automatic test_round_robin();
    int g, e;
    rst_n = 1'b0;
    req_valid_i = '0;
    #3 rst_n = 1'b1;
    model_ptr = 0;
    @(posedge clk); #1;
    randomize_fields();
    enable_i = 1'b1;
    req_valid_i = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin @(posedge clk); #2; end
      play_note(0, g, e);
      checks++;
      if (g != i % N) begin failures++; $display("FAIL rr_order step=%0d got=%0d expected=%0d", i, g, i % N); end
    end
  endtask

  task automatic test_clamp();
    int pv[7] = '{0, 200, 1, 2, 64, 65, 255};
    int pe[7] = '{2, 64, 2, 2, 64, 64, 64};
    int g, e, r;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      randomize_fields();
      r = $urandom_range(0, N - 1);
      per_a[r] = DW'(pv[i]);
      enable_i = 1'b1;
      req_valid_i = 4'b0001 << r;
      #1;
      acts.push_back('{1, 4'b0000, 1'b1, 1'b0});
      play_note(0, g, e);
      checks++;
      if (int'(seen_period) != pe[i]) begin
        failures++;
        $display("FAIL clamp req=%0d got=%0d expected=%0d", pv[i], seen_period, pe[i]);
      end
    end
  endtask

  task automatic test_enable();
    int g1, g2, e;
    @(posedge clk); #1;
    enable_i = 1'b0;
    req_valid_i = 4'b1111;
    randomize_fields();
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({busy_o, req_ready_o} !== 5'b0) begin
        failures++;
        $display("FAIL enable_gate cyc=%0d got=%b expected=00000", i, {busy_o, req_ready_o});
      end
      @(posedge clk); #1;
    end
    enable_i = 1'b1;
    #1;
    acts.push_back('{1, 4'b1111, 1'b0, 1'b0});
    acts.push_back('{S + PL + 2, 4'b1111, 1'b1, 1'b0});
    play_note(0, g1, e);
    @(posedge clk); #2;
    acts.push_back('{1, 4'b0000, 1'b1, 1'b0});
    play_note(0, g2, e);
    checks++;
    if (g2 != (g1 + 1) % N) begin failures++; $display("FAIL enable_next got=%0d expected=%0d", g2, (g1 + 1) % N); end
  endtask

  task automatic test_steal();
    int g, e, exp_end;
    @(posedge clk); #1;
    randomize_fields();
    per_a[0] = 8'd10;
    enable_i = 1'b1;
    req_valid_i = 4'b0001;
    #1;
    acts.push_back('{1, 4'b0000, 1'b1, 1'b0});
    acts.push_back('{S + PL + 10 + 3 + 5, 4'b0010, 1'b1, 1'b0});
    play_note(0, g, e);
`ifdef KS_SCHED_STEAL_EN
    exp_end = S + PL + 10 + 3 + 6;
`else
    exp_end = S + PL + 12 + MIN;
`endif
    checks++;
    if (e != exp_end) begin failures++; $display("FAIL steal_done_cycle got=%0d expected=%0d", e, exp_end); end
    @(posedge clk); #2;
    acts.push_back('{1, 4'b0000, 1'b1, 1'b0});
    play_note(0, g, e);
    checks++;
    if (g != 1) begin failures++; $display("FAIL steal_grant got=%0d expected=1", g); end
  endtask

  task automatic test_random();
    int g, e;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      randomize_fields();
      enable_i = 1'b1;
      req_valid_i = N'($urandom_range(1, 15));
      #1;
      acts.push_back('{1, N'($urandom), 1'($urandom), 1'b0});
      acts.push_back('{int'($urandom_range(2, 60)), N'($urandom), 1'($urandom), 1'b1});
      play_note(0, g, e);
      checks++;
      if (g < 0) begin failures++; $display("FAIL random_grant iter=%0d got=none expected=some", i); end
    end
  endtask

  task automatic test_async_reset();
    int g, e;
    logic [27:0] got;
    @(posedge clk); #1;
    randomize_fields();
    enable_i = 1'b1;
    req_valid_i = 4'b1111;
    #1;
    play_note(S + 2, g, e);
    checks++;
    if (pluck_o !== 1'b1) begin failures++; $display("FAIL pre_reset_pluck got=%b expected=1", pluck_o); end
    req_valid_i = '0;
    rst_n = 1'b0;
    #1;
    got = {period_o, dynamics_R_o, dynamics_en_o, drum_string_no, pluck_o, freeze_o,
           busy_o, grant_id_o, note_done_o, req_ready_o};
    checks++;
    if (got !== {8'd64, 20'd0}) begin
      failures++;
      $display("FAIL async_reset got=%h expected=%h", got, {8'd64, 20'd0});
    end
    #1 rst_n = 1'b1;
    model_ptr = 0;
    @(posedge clk); #1;
    req_valid_i = 4'b1111;
    #1;
    acts.push_back('{1, 4'b0000, 1'b1, 1'b0});
    play_note(0, g, e);
    checks++;
    if (g != 0) begin failures++; $display("FAIL post_reset_grant got=%0d expected=0", g); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < N; r++) begin
      per_a[r] = '0;
      dyn_a[r] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_clamp();
    test_enable();
    test_steal();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ks_note_scheduler.md
# ks_note_scheduler

Sequences and shares one `ks_string` voice among `NUM_REQ` note requesters. It round-robin arbitrates note requests and latches the winner's period, dynamics and drum/string mode. It then drives the voice through a fixed sequence: freeze and retune, pluck, noise burst, minimum hold. It sits directly in front of the string datapath, on the same clock (one cycle = one audio sample).

## Interface
- `NUM_REQ`, 4: number of requesters (≥2)
- `DATA_WIDTH`, 8: width of period and dynamics fields
- `MAX_LENGTH`, 64: longest legal string period (wavetable depth)
- `SETTLE_CYCLES`, 2: freeze duration while period changes (≥1)
- `PLUCK_CYCLES`, 4: pluck high duration (≥2, so the voice's edge detector sees it)
- `MIN_NOTE_CYCLES`, 256: minimum hold after the burst before the next grant (≥1, <2^16)

Ports:
- `clk_i` in 1: sample clock
- `rst_n` in 1: reset; asynchronous, active-low
- `enable_i` in 1: permits new grants
- `req_valid_i` in NUM_REQ: per-requester note request
- `req_ready_o` out NUM_REQ: one-hot grant/accept
- `req_period_i` in NUM_REQ*DATA_WIDTH: packed periods, requester r at `[r*DATA_WIDTH +: DATA_WIDTH]`
- `req_dyn_R_i` in NUM_REQ*DATA_WIDTH: packed dynamics coefficients
- `req_drum_i` in NUM_REQ: 1 = drum mode
- `period_o` out DATA_WIDTH: to voice `period_i`
- `dynamics_R_o` out DATA_WIDTH: to voice `dynamics_R_i`
- `dynamics_en_o` out 1: high when `dynamics_R_o` ≠ 0
- `drum_string_no` out 1: to voice
- `pluck_o` out 1: to voice
- `freeze_o` out 1: to voice
- `busy_o` out 1: state ≠ IDLE
- `grant_id_o` out $clog2(NUM_REQ): requester currently owning the voice
- `note_done_o` out 1: one-cycle pulse on the HOLD→IDLE transition

## Operation
- **FSM states:** IDLE, SETTLE, PLUCK, BURST, HOLD. A single 16-bit cycle counter `cnt` is cleared on every state entry.
- **IDLE**
  - If `enable_i` and any `req_valid_i` is high, the arbiter picks winner g.
  - `req_ready_o[g]` is high combinationally in that cycle; handshake = valid & ready.
  - Fields of g are latched; `grant_id_o` ← g; next state SETTLE.
  - No grant occurs in any other state; `req_ready_o` = 0 outside IDLE.
- **Arbitration:** round-robin. The priority pointer moves to g+1 (mod NUM_REQ) after each grant. Reset pointer = 0.
- **Period clamp:** latched period = 2 if request < 2; MAX_LENGTH if request > MAX_LENGTH; else the request.
- **SETTLE:** `freeze_o` = 1; outputs show the new period/dynamics/mode. Lasts SETTLE_CYCLES cycles, then → PLUCK.
- **PLUCK:** `pluck_o` = 1 for PLUCK_CYCLES cycles, then → BURST.
- **BURST:** lasts latched period + 2 cycles (covers the voice's noise burst), then → HOLD.
- **HOLD:** lasts MIN_NOTE_CYCLES cycles. On exit, `note_done_o` = 1 for one cycle and the next state is IDLE.
- **`enable_i` low:** blocks new grants only; a note in progress completes.
- **Requester drops valid:** a requester that deasserts valid before being granted is simply skipped. Requests are not queued.
- **Reset (async, any time, including mid-note):**
  - `period_o` = MAX_LENGTH
  - `dynamics_R_o` = 0, `dynamics_en_o` = 0
  - `drum_string_no` = 0, `pluck_o` = 0, `freeze_o` = 0
  - `busy_o` = 0, `grant_id_o` = 0, `req_ready_o` = 0, `note_done_o` = 0
  - state = IDLE, pointer = 0

## Timing
- All outputs are registered except `req_ready_o`.
- Handshake in cycle T:
  - `freeze_o` and the new `period_o` appear at T+1.
  - `pluck_o` is high from T+1+SETTLE_CYCLES for PLUCK_CYCLES cycles.
  - BURST spans the next P+2 cycles.
  - HOLD follows.
  - `note_done_o` is on the last HOLD cycle.
  - The earliest next grant is one cycle after `note_done_o`.
- Total note occupancy with no steal: SETTLE_CYCLES + PLUCK_CYCLES + (P+2) + MIN_NOTE_CYCLES cycles.
- `period_o`, `dynamics_R_o` and `drum_string_no` change only at SETTLE entry, and never while `pluck_o` is high.

## Configuration
- **`KS_SCHED_STEAL_EN` defined:** in HOLD, if `enable_i` and any `req_valid_i` is high, HOLD ends on the next cycle with `note_done_o` (voice stealing). Arbitration then happens in IDLE as normal.
- **Undefined:** HOLD always runs the full MIN_NOTE_CYCLES.

## Structure
- **Shared package `ks_sched_pkg`:**
  - state enum `ks_sched_state_t`
  - counter width constant `KS_SCHED_CNT_W` = 16
  - period clamp minimum `KS_MIN_PERIOD` = 2
- **Sub-module `ks_rr_arbiter`:**
  - parameter NUM_REQ
  - inputs: request vector, enable, advance strobe
  - outputs: one-hot grant and encoded index
  - owns the priority pointer

## Test plan
- **Single request:** req 0 valid, period 10, at T → ready[0] at T; freeze T+1..T+2; pluck T+3..T+6; BURST 12 cycles; `note_done_o` at T+274 with defaults.
- **Round-robin:** all four valid continuously → grants in order 0,1,2,3,0; `grant_id_o` matches each time.
- **Period clamp:** period 0 → `period_o` = 2; period 200 → `period_o` = 64.
- **Enable gating:** `enable_i` low with valid high → no ready, `busy_o` = 0. Raising it mid-note changes nothing until IDLE.
- **Async reset mid-PLUCK:** `pluck_o` drops immediately; all outputs take reset values; next grant goes to req 0.
- **With `KS_SCHED_STEAL_EN`:** req 1 arrives 5 cycles into HOLD → `note_done_o` next cycle, grant to req 1 one cycle later. Without the macro, the grant waits for the full HOLD.
